// File: rtl/pattern_applier.sv
// Pattern applier/comparator: drives stored stimuli onto a combinational DUT,
// waits a fixed settle time, then checks the response under a care mask.
module pattern_applier #(
    parameter int NINPUTS  = 5,
    parameter int NOUTPUTS = 1,
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int SETTLE   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pat_we,
    input  logic [AW-1:0]       pat_addr,
    input  logic [NINPUTS-1:0]  pat_stim,
    input  logic [NOUTPUTS-1:0] pat_exp,
    input  logic [NOUTPUTS-1:0] pat_mask,
    input  logic [AW:0]         npat,
    input  logic                start,
    output logic [NINPUTS-1:0]  dut_in,
    input  logic [NOUTPUTS-1:0] dut_out,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [AW-1:0]       pattern_number,
    output logic [AW:0]         fail_count,
    output logic                first_fail_valid,
    output logic [AW-1:0]       first_fail_pattern
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] FC_MAX  = '1;

    typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SETTLE, S_STROBE, S_FINISH} state_t;

    logic [NINPUTS-1:0]  stim_mem [DEPTH];
    logic [NOUTPUTS-1:0] exp_mem  [DEPTH];
    logic [NOUTPUTS-1:0] mask_mem [DEPTH];

    state_t              state_q, state_d;
    logic [NINPUTS-1:0]  dut_in_q, dut_in_d;
    logic                busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [AW-1:0]       pn_q, pn_d, ffp_q, ffp_d;
    logic [AW:0]         fc_q, fc_d, npat_q, npat_d;
    logic                ffv_q, ffv_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                mismatch;

    // Pattern memory has no reset; writes are locked out for the whole run.
    always_ff @(posedge clk) begin
        if (pat_we && !busy_q && ({1'b0, pat_addr} < DEPTH_C)) begin
            stim_mem[pat_addr] <= pat_stim;
            exp_mem[pat_addr]  <= pat_exp;
            mask_mem[pat_addr] <= pat_mask;
        end
    end

    assign mismatch = |((dut_out ^ exp_mem[pn_q]) & mask_mem[pn_q]);

    always_comb begin
        state_d  = state_q;
        dut_in_d = dut_in_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        pn_d     = pn_q;
        fc_d     = fc_q;
        ffv_d    = ffv_q;
        ffp_d    = ffp_q;
        npat_d   = npat_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    fc_d   = '0;
                    ffv_d  = 1'b0;
                    ffp_d  = '0;
                    pass_d = 1'b0;
                    npat_d = (npat > DEPTH_C) ? DEPTH_C : npat;
                    if (npat == '0) begin
                        state_d = S_FINISH;
                    end else begin
                        pn_d    = '0;
                        busy_d  = 1'b1;
                        state_d = S_APPLY;
                    end
                end
            end
            S_APPLY: begin
                dut_in_d = stim_mem[pn_q];
                cnt_d    = CW'(SETTLE - 1);
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == '0) state_d = S_STROBE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_STROBE: begin
                if (mismatch) begin
                    if (fc_q != FC_MAX) fc_d = fc_q + 1'b1;
                    if (!ffv_q) begin
                        ffv_d = 1'b1;
                        ffp_d = pn_q;
                    end
                end
                if ({1'b0, pn_q} == npat_q - 1'b1) begin
                    state_d = S_FINISH;
                end else begin
                    pn_d    = pn_q + 1'b1;
                    state_d = S_APPLY;
                end
            end
            S_FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (fc_q == '0);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            dut_in_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            pn_q     <= '0;
            fc_q     <= '0;
            ffv_q    <= 1'b0;
            ffp_q    <= '0;
            npat_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            dut_in_q <= dut_in_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            pn_q     <= pn_d;
            fc_q     <= fc_d;
            ffv_q    <= ffv_d;
            ffp_q    <= ffp_d;
            npat_q   <= npat_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dut_in             = dut_in_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign pass               = pass_q;
    assign pattern_number     = pn_q;
    assign fail_count         = fc_q;
    assign first_fail_valid   = ffv_q;
    assign first_fail_pattern = ffp_q;

endmodule

// File: tb/tb_pattern_applier.sv
// Bench for pattern_applier: two instances (SETTLE=2 and SETTLE=3) each driving
// a mux DUT model whose response only becomes valid SETTLE cycles after its input.
module tb_pattern_applier;

    logic       clk = 1'b0;
    logic       rst;
    logic       pat_we;
    logic [3:0] pat_addr;
    logic [4:0] pat_stim;
    logic [0:0] pat_exp, pat_mask;
    logic [4:0] npat;
    logic       start_a, start_b;

    logic [4:0] dut_in_a, dut_in_b;
    logic [0:0] dut_out_a, dut_out_b;
    logic       busy_a, done_a, pass_a, ffv_a;
    logic       busy_b, done_b, pass_b, ffv_b;
    logic [3:0] pn_a, ffp_a, pn_b, ffp_b;
    logic [4:0] fc_a, fc_b;

    int tests = 0;
    int fails = 0;

    logic [4:0] m_stim [16];
    logic       m_exp  [16];
    logic       m_mask [16];

    always #5 clk = ~clk;

    pattern_applier #(.NINPUTS(5), .NOUTPUTS(1), .DEPTH(16), .AW(4), .SETTLE(2)) u_a (
        .clk(clk), .rst(rst), .pat_we(pat_we), .pat_addr(pat_addr), .pat_stim(pat_stim),
        .pat_exp(pat_exp), .pat_mask(pat_mask), .npat(npat), .start(start_a),
        .dut_in(dut_in_a), .dut_out(dut_out_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .pattern_number(pn_a), .fail_count(fc_a), .first_fail_valid(ffv_a),
        .first_fail_pattern(ffp_a));

    pattern_applier #(.NINPUTS(5), .NOUTPUTS(1), .DEPTH(16), .AW(4), .SETTLE(3)) u_b (
        .clk(clk), .rst(rst), .pat_we(pat_we), .pat_addr(pat_addr), .pat_stim(pat_stim),
        .pat_exp(pat_exp), .pat_mask(pat_mask), .npat(npat), .start(start_b),
        .dut_in(dut_in_b), .dut_out(dut_out_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .pattern_number(pn_b), .fail_count(fc_b), .first_fail_valid(ffv_b),
        .first_fail_pattern(ffp_b));

    function automatic logic mux(input logic [4:0] s);
        return s[2] ? s[1] : s[0];
    endfunction

    // Slow DUT: output reflects the input from SETTLE cycles ago.
    logic [4:0] dla [2];
    logic [4:0] dlb [3];
    always @(posedge clk) begin
        dla[0] <= dut_in_a; dla[1] <= dla[0];
        dlb[0] <= dut_in_b; dlb[1] <= dlb[0]; dlb[2] <= dlb[1];
    end
    assign dut_out_a = mux(dla[1]);
    assign dut_out_b = mux(dlb[2]);

    function automatic logic [4:0] bstim(input int i);
        case (i)
            0: return 5'b01001;
            1: return 5'b01010;
            2: return 5'b01100;
            3: return 5'b01110;
            default: return 5'b01000 | 5'(i & 7);
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Caller is at posedge+1; returns at posedge+1 after the write edge.
    task automatic wr(input int addr, input logic [4:0] s, input logic e, input logic m);
        pat_we = 1'b1; pat_addr = 4'(addr); pat_stim = s; pat_exp = e; pat_mask = m;
        @(posedge clk); #1;
        pat_we = 1'b0;
        if (addr < 16) begin m_stim[addr] = s; m_exp[addr] = e; m_mask[addr] = m; end
    endtask

    task automatic load_base(input logic [15:0] wrong, input logic [15:0] moff);
        for (int i = 0; i < 16; i++) wr(i, bstim(i), mux(bstim(i)) ^ wrong[i], ~moff[i]);
    endtask

    task automatic run(input bit sel_b, input int n, output int lat, output bit busy_seen);
        npat = 5'(n);
        if (sel_b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        lat = 0;
        busy_seen = sel_b ? busy_b : busy_a;
        while (!(sel_b ? done_b : done_a) && lat < 300) begin
            @(posedge clk); #1;
            lat++;
            if (sel_b ? busy_b : busy_a) busy_seen = 1'b1;
        end
    endtask

    typedef struct {
        int          n;
        logic [15:0] wrong;
        logic [15:0] moff;
        int          fc;
        bit          ffv;
        int          ffp;
        bit          pass;
        int          lat;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int lat, nn, efc, effp, changes, last;
        bit bs, effv;
        logic [4:0] prev;

        rst = 1'b1; pat_we = 0; pat_addr = 0; pat_stim = 0; pat_exp = 0; pat_mask = 0;
        npat = 0; start_a = 0; start_b = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy_a, 0);   chk("rst_done", done_a, 0);
        chk("rst_pass", pass_a, 0);   chk("rst_pn", pn_a, 0);
        chk("rst_fc", fc_a, 0);       chk("rst_ffv", ffv_a, 0);
        chk("rst_ffp", ffp_a, 0);     chk("rst_dut_in", dut_in_a, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        //        n   wrong     moff      fc ffv ffp pass lat
        tbl[0] = '{4,  16'h0000, 16'h0000, 0, 0, 0, 1, 17};
        tbl[1] = '{4,  16'h0004, 16'h0000, 1, 1, 2, 0, 17};
        tbl[2] = '{4,  16'h0004, 16'h0004, 0, 0, 0, 1, 17};
        tbl[3] = '{16, 16'hFFFF, 16'h0000, 16, 1, 0, 0, 65};
        tbl[4] = '{0,  16'h0000, 16'h0000, 0, 0, 0, 1, 1};
        tbl[5] = '{20, 16'h8200, 16'h0000, 2, 1, 9, 0, 65};
        tbl[6] = '{1,  16'h0001, 16'h0000, 1, 1, 0, 0, 5};

        for (int k = 0; k < 7; k++) begin
            load_base(tbl[k].wrong, tbl[k].moff);
            run(1'b0, tbl[k].n, lat, bs);
            chk($sformatf("t%0d_lat", k), lat, tbl[k].lat);
            chk($sformatf("t%0d_fc", k), fc_a, tbl[k].fc);
            chk($sformatf("t%0d_pass", k), pass_a, tbl[k].pass);
            chk($sformatf("t%0d_busy_seen", k), bs, tbl[k].n != 0);
            if (tbl[k].n != 0) begin
                chk($sformatf("t%0d_ffv", k), ffv_a, tbl[k].ffv);
                chk($sformatf("t%0d_ffp", k), ffp_a, tbl[k].ffp);
                nn = (tbl[k].n > 16) ? 16 : tbl[k].n;
                chk($sformatf("t%0d_dut_in", k), dut_in_a, bstim(nn - 1));
            end
            @(posedge clk); #1;
            chk($sformatf("t%0d_done_1cyc", k), done_a, 0);
            chk($sformatf("t%0d_pass_hold", k), pass_a, tbl[k].pass);
        end

        // Reset during the settle phase of pattern 1
        load_base(16'h0004, 16'h0000);
        npat = 5'd4; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_pn", pn_a, 1);
        chk("mid_busy", busy_a, 1);
        rst = 1'b1; #1;
        chk("mr_busy", busy_a, 0);    chk("mr_pn", pn_a, 0);
        chk("mr_dut_in", dut_in_a, 0); chk("mr_fc", fc_a, 0);
        chk("mr_ffv", ffv_a, 0);      chk("mr_ffp", ffp_a, 0);
        chk("mr_pass", pass_a, 0);    chk("mr_done", done_a, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        changes = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (done_a) changes++;
        end
        chk("mr_no_done", changes, 0);
        run(1'b0, 4, lat, bs);
        chk("mr_rerun_lat", lat, 17);
        chk("mr_rerun_fc", fc_a, 1);
        chk("mr_rerun_ffp", ffp_a, 2);

        // Start and pattern write while busy must both be ignored
        load_base(16'h0000, 16'h0000);
        npat = 5'd4; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        lat = 0;
        while (!done_a && lat < 300) begin
            if (lat == 6) begin
                start_a = 1'b1; npat = 5'd0;
                pat_we = 1'b1; pat_addr = 4'd1; pat_stim = bstim(1); pat_exp = ~mux(bstim(1)); pat_mask = 1'b1;
            end else begin
                start_a = 1'b0; pat_we = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start_a = 1'b0; pat_we = 1'b0;
        chk("busy_start_lat", lat, 17);
        chk("busy_start_pass", pass_a, 1);
        run(1'b0, 4, lat, bs);
        chk("busy_we_fc", fc_a, 0);
        chk("busy_we_pass", pass_a, 1);

        // SETTLE=3: each stimulus held 5 cycles
        load_base(16'h0000, 16'h0000);
        npat = 5'd4; start_b = 1'b1;
        prev = dut_in_b;
        @(posedge clk); #1;
        start_b = 1'b0;
        lat = 0; changes = 0; last = -1;
        while (!done_b && lat < 300) begin
            @(posedge clk); #1;
            lat++;
            if (dut_in_b != prev) begin
                if (last >= 0) chk($sformatf("b_hold%0d", changes), lat - last, 5);
                last = lat; changes++;
                prev = dut_in_b;
            end
        end
        chk("b_changes", changes, 4);
        chk("b_lat", lat, 21);
        chk("b_pass", pass_b, 1);
        chk("b_fc", fc_b, 0);

        // Random contents and run lengths against the reference model
        for (int it = 0; it < 25; it++) begin
            for (int j = 0; j < 5; j++)
                wr($urandom_range(0, 15), 5'($urandom), 1'($urandom), 1'($urandom));
            nn = $urandom_range(0, 20);
            run(1'b0, nn, lat, bs);
            if (nn > 16) nn = 16;
            efc = 0; effv = 0; effp = 0;
            for (int i = 0; i < nn; i++) begin
                if (((mux(m_stim[i]) ^ m_exp[i]) & m_mask[i]) != 0) begin
                    if (!effv) begin effv = 1; effp = i; end
                    efc++;
                end
            end
            chk($sformatf("r%0d_lat", it), lat, nn * 4 + 1);
            chk($sformatf("r%0d_fc", it), fc_a, efc);
            chk($sformatf("r%0d_pass", it), pass_a, efc == 0);
            if (nn != 0) begin
                chk($sformatf("r%0d_ffv", it), ffv_a, effv);
                if (effv) chk($sformatf("r%0d_ffp", it), ffp_a, effp);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pattern_applier.md
Name: pattern_applier

Overview:
- Hardware pattern applier and comparator that sits directly upstream of the combinational DUT (the 5-input/1-output mux) and consumes its response.
- Holds a small pattern memory loaded over a write port. On start, it drives each stimulus onto the DUT inputs and waits a programmable settle time.
- It then strobes the DUT outputs, compares them against the expected values under a care mask, and reports the pattern number, the fail count and the first failing pattern.

Parameters:
- NINPUTS, 5: stimulus width. Bit mapping: bit0=a, bit1=b, bit2=com, bit3=vdd, bit4=vss.
- NOUTPUTS, 1: response width. Bit0=s.
- DEPTH, 16: number of pattern slots.
- AW, 4: address width; DEPTH <= 2**AW.
- SETTLE, 2: cycles between stimulus update and strobe; legal range >= 1.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- pat_we  in  1  write enable for the pattern memory.
- pat_addr  in  AW  write address.
- pat_stim  in  NINPUTS  stimulus to store.
- pat_exp  in  NOUTPUTS  expected response to store.
- pat_mask  in  NOUTPUTS  care mask: 1 = compare, 0 = X / don't-care.
- npat  in  AW+1  number of patterns to run, range 0..DEPTH. Sampled on start.
- start  in  1  single-cycle run request.
- dut_in  out  NINPUTS  stimulus driven to the DUT.
- dut_out  in  NOUTPUTS  DUT response.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  valid from done until next start: 1 iff fail_count==0.
- pattern_number  out  AW  index of the pattern currently applied.
- fail_count  out  AW+1  mismatching patterns in the current run; saturates at all-ones.
- first_fail_valid  out  1  a mismatch has occurred in this run.
- first_fail_pattern  out  AW  index of the first mismatching pattern.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; dut_in=0; busy=0; done=0; pass=0.
  - pattern_number=0; fail_count=0; first_fail_valid=0; first_fail_pattern=0.
  - Pattern memory contents are not reset.
- Memory:
  - Synchronous write when pat_we=1 and busy=0.
  - Writes while busy=1 are ignored.
  - pat_addr >= DEPTH is ignored.
- FSM states: IDLE, APPLY, SETTLE, STROBE, FINISH.
- IDLE:
  - start=1 with npat==0 -> FINISH directly. Result: pass=1, fail_count=0.
  - start=1 with npat>0 -> clear fail_count/first_fail_*, set pattern_number=0, busy=1 -> APPLY.
  - start is ignored in every other state.
- APPLY: dut_in <= stim[pattern_number]; settle counter <= SETTLE-1 -> SETTLE.
- SETTLE: decrement the counter; at 0 -> STROBE. dut_in is held stable throughout.
- STROBE: the response is sampled this cycle.
  - Mismatch = |((dut_out ^ exp) & mask).
  - On mismatch: fail_count increments (saturating). If first_fail_valid==0, latch first_fail_pattern=pattern_number and set first_fail_valid=1.
  - If pattern_number == npat-1 -> FINISH; else pattern_number+1 -> APPLY.
- FINISH: busy=0, done=1 for exactly one cycle, pass=(fail_count==0) -> IDLE.
- Outputs after a run:
  - dut_in keeps the last stimulus.
  - fail_count, first_fail_* and pass hold until the next accepted start.
- Timing:
  - Cycles per pattern = SETTLE+2: APPLY, SETTLE cycles, STROBE.
  - Run length = npat*(SETTLE+2)+1 cycles from the start edge to the done pulse.
- Edge cases:
  - An all-zero mask never fails.
  - npat > DEPTH is clamped to DEPTH.
  - Reset mid-run aborts immediately with no done pulse.

Test Plan:
1. Basic run. Bench model s = com ? b : a. Load 4 patterns {a,b,com} = 100, 010, 001(s=0), 011(s=1) with vdd=1, vss=0, exp=correct, mask=1; npat=4 -> done after 4*(SETTLE+2)+1 = 17 cycles, pass=1, fail_count=0.
2. Single mismatch. Same load, but exp of pattern 2 set to 1 -> fail_count=1, first_fail_valid=1, first_fail_pattern=2, pass=0.
3. Mask and saturation. Pattern 2 exp wrong but mask=0 -> pass=1. Then all 16 exp wrong with mask=1, npat=16 -> fail_count=16, first_fail_pattern=0.
4. Boundary npat values. npat=0 -> done one cycle after start, pass=1, busy never asserted. npat=20 -> behaves as 16.
5. Reset mid-run. Assert rst during SETTLE of pattern 1 -> all outputs 0 immediately, no done pulse. A new start then runs normally with the memory contents intact.
6. Settle and protocol checks. With SETTLE=3, dut_in is stable for 5 cycles per pattern. pat_we during busy leaves memory unchanged. A start pulse during busy is ignored.
